qmem_arb2: RTL and testbench

- Two-master, one-slave arbiter for the qmem bus.
- Lets two qmem masters (e.g. CPU and a DMA/bench master) share a single qmem slave, typically the qmem SRAM bridge.
- Round-robin grant, held for one whole access.
- Watchdog aborts an access with err if the slave never answers, so a hung slave cannot lock both masters.

---
 rtl/qmem_pkg.sv | 13 +
 rtl/qmem_rr2.sv | 20 ++
 rtl/qmem_arb2.sv | 132 +++++++++++++
 tb/tb_qmem_arb2.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qmem_pkg.sv
// Shared qmem definitions: default bus widths and arbiter state encoding.
package qmem_pkg;

    localparam int QAW_DEF = 32;
    localparam int QDW_DEF = 32;
    localparam int QSW_DEF = QDW_DEF / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } qmem_state_t;

endpackage

// File: rtl/qmem_rr2.sv
// Two-way round-robin pick. rr is the index of the master served last, so a
// tie goes to the other one. Purely combinational.
module qmem_rr2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] win
);

    // one-hot winner; tie broken away from the last-served master
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = rr ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/qmem_arb2.sv
// Two-master, one-slave qmem arbiter. Round-robin grant held for a whole
// access, one idle bubble between accesses, and a watchdog that aborts an
// access with err when the slave never answers.
module qmem_arb2
    import qmem_pkg::*;
#(
    parameter int QAW = QAW_DEF,
    parameter int QDW = QDW_DEF,
    parameter int QSW = QDW / 8,
    parameter int TO  = 64,
    parameter int TOW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           m0_cs,
    input  logic           m0_we,
    input  logic [QSW-1:0] m0_sel,
    input  logic [QAW-1:0] m0_adr,
    input  logic [QDW-1:0] m0_dat_w,
    output logic [QDW-1:0] m0_dat_r,
    output logic           m0_ack,
    output logic           m0_err,
    input  logic           m1_cs,
    input  logic           m1_we,
    input  logic [QSW-1:0] m1_sel,
    input  logic [QAW-1:0] m1_adr,
    input  logic [QDW-1:0] m1_dat_w,
    output logic [QDW-1:0] m1_dat_r,
    output logic           m1_ack,
    output logic           m1_err,
    output logic           s_cs,
    output logic           s_we,
    output logic [QSW-1:0] s_sel,
    output logic [QAW-1:0] s_adr,
    output logic [QDW-1:0] s_dat_w,
    input  logic [QDW-1:0] s_dat_r,
    input  logic           s_ack,
    input  logic           s_err,
    output logic [1:0]     gnt,
    output logic           to_evt
);

    qmem_state_t    state, state_nx;
    logic           gidx;      // granted master index, valid in BUSY
    logic           rr;        // index of the master served last
    logic [TOW-1:0] cnt;       // BUSY cycles without a slave response
    logic [1:0]     win;
    logic           busy, g_cs, resp, tmo, done;

    qmem_rr2 u_rr (
        .req ({m1_cs, m0_cs}),
        .rr  (rr),
        .win (win)
    );

    // Outputs are also masked while rst is high so nothing leaks out of an
    // access that reset is tearing down.
    assign busy = (state == ST_BUSY) && !rst;
    assign g_cs = gidx ? m1_cs : m0_cs;
    assign resp = s_ack | s_err;
    // A slave response in the limit cycle wins over the watchdog.
    assign tmo  = (TO > 0) && busy && g_cs && !resp && (cnt == TOW'(TO - 1));
    // Access ends on response, watchdog abort, or the master dropping cs.
    assign done = busy && (resp || tmo || !g_cs);

    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    // state register, grant capture, rr pointer and watchdog counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            gidx  <= 1'b0;
            rr    <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE) begin
                cnt <= '0;
                if (|win) gidx <= win[1];
            end else if (done) begin
                rr  <= gidx;
                cnt <= '0;
            end else begin
                cnt <= cnt + TOW'(1);
            end
        end
    end

    // next-state: arbitrate in IDLE, return to IDLE when the access ends
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (|win) state_nx = ST_BUSY;
            ST_BUSY: if (done) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // output mux: granted master drives the slave, slave response goes back
    always_comb begin
        s_cs    = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        gnt     = 2'b00;
        to_evt  = 1'b0;
        if (busy) begin
            s_cs    = g_cs & ~tmo;
            s_we    = gidx ? m1_we    : m0_we;
            s_sel   = gidx ? m1_sel   : m0_sel;
            s_adr   = gidx ? m1_adr   : m0_adr;
            s_dat_w = gidx ? m1_dat_w : m0_dat_w;
            to_evt  = tmo;
            if (gidx) begin
                gnt    = 2'b10;
                m1_ack = s_ack;
                m1_err = s_err | tmo;
            end else begin
                gnt    = 2'b01;
                m0_ack = s_ack;
                m0_err = s_err | tmo;
            end
        end
    end

endmodule

// File: tb/tb_qmem_arb2.sv
// Bench for qmem_arb2: SRAM slave model with selectable latency behaviour,
// grant-order reference model, and one task per scenario.
module tb_qmem_arb2;

    localparam int QAW = 32;
    localparam int QDW = 32;
    localparam int QSW = 4;
    localparam int TO  = 8;
    localparam int TOW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           m0_cs, m0_we, m1_cs, m1_we;
    logic [QSW-1:0] m0_sel, m1_sel;
    logic [QAW-1:0] m0_adr, m1_adr;
    logic [QDW-1:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r;
    logic           m0_ack, m0_err, m1_ack, m1_err;
    logic           s_cs, s_we;
    logic [QSW-1:0] s_sel;
    logic [QAW-1:0] s_adr;
    logic [QDW-1:0] s_dat_w;
    logic [QDW-1:0] s_dat_r = '0;
    logic           s_ack = 1'b0;
    logic           s_err = 1'b0;
    logic [1:0]     gnt;
    logic           to_evt;

    qmem_arb2 #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .TO(TO), .TOW(TOW)) dut (
        .clk(clk), .rst(rst),
        .m0_cs(m0_cs), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cs(m1_cs), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cs(s_cs), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr), .s_dat_w(s_dat_w),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .gnt(gnt), .to_evt(to_evt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model (SRAM) ----------------
    // mode 0: random 0..3 wait cycles, 1: never answers, 2: fixed wait fix_lat
    logic [31:0] smem    [0:255] = '{default: '0};
    logic [31:0] ref_mem [0:255] = '{default: '0};
    int slave_mode = 0;
    int fix_lat = 0;
    int wcnt = 0;
    int cur_lat = 0;

    always @(posedge clk) begin
        if (rst) begin
            s_ack <= 1'b0;
            wcnt  <= 0;
        end else begin
            s_ack <= 1'b0;
            if (!s_cs) begin
                wcnt    <= 0;
                cur_lat <= (slave_mode == 2) ? fix_lat : int'($urandom_range(0, 3));
            end else if (!s_ack && slave_mode != 1) begin
                if (wcnt == cur_lat) begin
                    s_ack <= 1'b1;
                    wcnt  <= 0;
                    if (s_we) begin
                        for (int b = 0; b < 4; b++)
                            if (s_sel[b]) smem[s_adr[9:2]][8*b +: 8] <= s_dat_w[8*b +: 8];
                    end else begin
                        s_dat_r <= smem[s_adr[9:2]];
                    end
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // ---------------- access monitor ----------------
    typedef struct {
        int   idx;
        int   st;
        int   en;
        logic err;
    } acc_t;

    acc_t       alog[$];
    logic [1:0] pgnt = 2'b00;
    int         cur_st = 0;
    int         m1_ack_n = 0;

    always @(negedge clk) begin
        if (gnt != 2'b00 && pgnt == 2'b00) cur_st <= cyc;
        if (gnt == 2'b01 && (m0_ack || m0_err)) alog.push_back('{0, cur_st, cyc, m0_err});
        if (gnt == 2'b10 && (m1_ack || m1_err)) alog.push_back('{1, cur_st, cyc, m1_err});
        if (m1_ack) m1_ack_n <= m1_ack_n + 1;
        pgnt <= gnt;
    end

    // ---------------- reference model ----------------
    logic model_last = 1'b1;
    int   eord[$];

    // expected service order when masters keep n0/n1 requests pending
    task automatic model_order(input int n0, input int n1);
        eord.delete();
        while (n0 > 0 || n1 > 0) begin
            int w;
            if (n0 > 0 && n1 > 0) w = model_last ? 0 : 1;
            else                  w = (n0 > 0) ? 0 : 1;
            eord.push_back(w);
            model_last = w[0];
            if (w == 0) n0--; else n1--;
        end
    endtask

    function automatic void ref_wr(input logic [31:0] adr, input logic [31:0] dat,
                                   input logic [3:0] sel);
        for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[adr[9:2]][8*b +: 8] = dat[8*b +: 8];
    endfunction

    // one master access, called at posedge+1; ends at posedge+1 after response
    task automatic mreq(input int m, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [31:0] rd, output logic ack, output logic err);
        int n;
        if (m == 0) begin
            m0_cs = 1'b1; m0_we = we; m0_adr = adr; m0_dat_w = dat; m0_sel = sel;
        end else begin
            m1_cs = 1'b1; m1_we = we; m1_adr = adr; m1_dat_w = dat; m1_sel = sel;
        end
        ack = 1'b0; err = 1'b0; rd = '0; n = 0;
        while (!ack && !err && n < 200) begin
            @(negedge clk);
            ack = (m == 0) ? m0_ack : m1_ack;
            err = (m == 0) ? m0_err : m1_err;
            rd  = (m == 0) ? m0_dat_r : m1_dat_r;
            n++;
        end
        @(posedge clk); #1;
        if (m == 0) m0_cs = 1'b0; else m1_cs = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        m0_cs = 1'b1; m0_adr = 32'h55aa_0004; m0_we = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00 || s_cs !== 1'b0 || to_evt !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: gnt=%b s_cs=%b to_evt=%b exp 00/0/0", gnt, s_cs, to_evt);
        end
        checks++;
        if (s_adr !== 32'h0 || s_we !== 1'b0) begin
            errors++; $display("FAIL reset_sbus: s_adr=%h s_we=%b exp 0", s_adr, s_we);
        end
        checks++;
        if (m0_ack !== 1'b0 || m0_err !== 1'b0 || m1_ack !== 1'b0 || m1_err !== 1'b0) begin
            errors++; $display("FAIL reset_resp: acks/errs not zero");
        end
        @(posedge clk); #1;
        m0_cs = 1'b0; m0_adr = '0; m0_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL reset_idle: gnt=%b exp 00", gnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [31:0] rd;
        logic a, e;
        int n0, n;
        n0 = m1_ack_n;
        ref_wr(32'h0, 32'hdeadbeef, 4'hf);
        m0_cs = 1'b1; m0_we = 1'b1; m0_adr = 32'h0; m0_dat_w = 32'hdeadbeef; m0_sel = 4'hf;
        @(negedge clk);
        checks++;
        if (s_cs !== 1'b0) begin
            errors++; $display("FAIL single_arb_cycle: s_cs=%b exp 0", s_cs);
        end
        @(negedge clk);
        checks++;
        if (s_cs !== 1'b1 || gnt !== 2'b01 || s_we !== 1'b1 || s_dat_w !== 32'hdeadbeef) begin
            errors++; $display("FAIL single_grant: s_cs=%b gnt=%b s_we=%b s_dat_w=%h exp 1/01/1/deadbeef",
                               s_cs, gnt, s_we, s_dat_w);
        end
        n = 0;
        while (!m0_ack && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (m0_ack !== 1'b1) begin
            errors++; $display("FAIL single_wr_ack: m0_ack=%b exp 1", m0_ack);
        end
        @(posedge clk); #1;
        m0_cs = 1'b0;
        mreq(0, 1'b0, 32'h0, 32'h0, 4'hf, rd, a, e);
        checks++;
        if (a !== 1'b1 || rd !== ref_mem[0]) begin
            errors++; $display("FAIL single_rd: ack=%b data=%h exp 1/%h", a, rd, ref_mem[0]);
        end
        checks++;
        if (m1_ack_n != n0) begin
            errors++; $display("FAIL single_m1_quiet: m1 acks=%0d exp 0", m1_ack_n - n0);
        end
        model_order(2, 0);
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd0, rd1;
        logic a0, e0, a1, e1;
        alog.delete();
        ref_wr(32'h10, 32'h11111111, 4'hf);
        ref_wr(32'h14, 32'h22222222, 4'hf);
        fork
            mreq(0, 1'b1, 32'h10, 32'h11111111, 4'hf, rd0, a0, e0);
            mreq(1, 1'b1, 32'h14, 32'h22222222, 4'hf, rd1, a1, e1);
        join
        model_order(1, 1);
        checks++;
        if (alog.size() != 2) begin
            errors++; $display("FAIL simul_count: accesses=%0d exp 2", alog.size());
        end else begin
            checks++;
            if (alog[0].idx != eord[0] || alog[1].idx != eord[1]) begin
                errors++; $display("FAIL simul_order: got %0d,%0d exp %0d,%0d",
                                   alog[0].idx, alog[1].idx, eord[0], eord[1]);
            end
            checks++;
            if (alog[1].st != alog[0].en + 2) begin
                errors++; $display("FAIL simul_bubble: start=%0d exp %0d", alog[1].st, alog[0].en + 2);
            end
        end
        mreq(1, 1'b0, 32'h10, 32'h0, 4'hf, rd1, a1, e1);
        mreq(0, 1'b0, 32'h14, 32'h0, 4'hf, rd0, a0, e0);
        checks++;
        if (rd1 !== ref_mem[32'h10 >> 2] || rd0 !== ref_mem[32'h14 >> 2] || !a0 || !a1) begin
            errors++; $display("FAIL simul_readback: %h %h exp %h %h", rd1, rd0,
                               ref_mem[32'h10 >> 2], ref_mem[32'h14 >> 2]);
        end
        model_order(0, 1);
        model_order(1, 0);
    endtask

    task automatic fair_master(input int m, input int n, input logic [31:0] base);
        logic [31:0] rd, adr, d, ex;
        logic [3:0]  sel;
        logic        a, e, we;
        for (int k = 0; k < n; k++) begin
            adr = base + 32'($urandom_range(0, 15)) * 4;
            d   = $urandom;
            we  = 1'($urandom_range(0, 1));
            sel = we ? 4'($urandom_range(1, 15)) : 4'hf;
            if (we) ref_wr(adr, d, sel);
            ex = ref_mem[adr[9:2]];
            mreq(m, we, adr, d, sel, rd, a, e);
            checks++;
            if (a !== 1'b1 || e !== 1'b0 || (!we && rd !== ex)) begin
                errors++; $display("FAIL fair_access m%0d: ack=%b err=%b rd=%h exp ack 1 rd %h",
                                   m, a, e, rd, ex);
            end
        end
    endtask

    task automatic test_fairness();
        for (int r = 0; r < 3; r++) begin
            int n0, n1;
            n0 = (r == 0) ? 2 : int'($urandom_range(2, 4));
            n1 = (r == 0) ? 2 : int'($urandom_range(2, 4));
            alog.delete();
            fork
                fair_master(0, n0, 32'h100);
                fair_master(1, n1, 32'h200);
            join
            model_order(n0, n1);
            checks++;
            if (alog.size() != n0 + n1) begin
                errors++; $display("FAIL fair_count: accesses=%0d exp %0d", alog.size(), n0 + n1);
            end else begin
                for (int i = 0; i < alog.size(); i++) begin
                    checks++;
                    if (alog[i].idx != eord[i]) begin
                        errors++; $display("FAIL fair_order[%0d]: m%0d exp m%0d", i, alog[i].idx, eord[i]);
                    end
                    if (i > 0) begin
                        checks++;
                        if (alog[i].st != alog[i-1].en + 2) begin
                            errors++; $display("FAIL fair_bubble[%0d]: start=%0d exp %0d",
                                               i, alog[i].st, alog[i-1].en + 2);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic a, e;
        slave_mode = 1;
        m0_cs = 1'b1; m0_we = 1'b0; m0_adr = 32'h40; m0_sel = 4'hf;
        @(posedge clk);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k < TO) begin
                checks++;
                if (s_cs !== 1'b1 || m0_err !== 1'b0 || to_evt !== 1'b0 || gnt !== 2'b01) begin
                    errors++; $display("FAIL to_wait[%0d]: s_cs=%b err=%b to_evt=%b gnt=%b exp 1/0/0/01",
                                       k, s_cs, m0_err, to_evt, gnt);
                end
            end else begin
                checks++;
                if (m0_err !== 1'b1 || m0_ack !== 1'b0) begin
                    errors++; $display("FAIL to_err: err=%b ack=%b exp 1/0", m0_err, m0_ack);
                end
                checks++;
                if (to_evt !== 1'b1 || s_cs !== 1'b0) begin
                    errors++; $display("FAIL to_evt: to_evt=%b s_cs=%b exp 1/0", to_evt, s_cs);
                end
            end
        end
        @(posedge clk); #1;
        m0_cs = 1'b0;
        slave_mode = 0;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00 || to_evt !== 1'b0) begin
            errors++; $display("FAIL to_idle: gnt=%b to_evt=%b exp 00/0", gnt, to_evt);
        end
        @(posedge clk); #1;
        model_order(1, 0);
        ref_wr(32'h44, 32'hcafe0001, 4'hf);
        mreq(1, 1'b1, 32'h44, 32'hcafe0001, 4'hf, rd, a, e);
        mreq(1, 1'b0, 32'h44, 32'h0, 4'hf, rd, a, e);
        checks++;
        if (a !== 1'b1 || e !== 1'b0 || rd !== ref_mem[32'h44 >> 2]) begin
            errors++; $display("FAIL to_recover: ack=%b err=%b rd=%h exp 1/0/%h", a, e, rd, ref_mem[32'h44 >> 2]);
        end
        model_order(0, 2);
    endtask

    task automatic test_ack_on_limit();
        slave_mode = 2;
        fix_lat = TO - 2;
        m0_cs = 1'b1; m0_we = 1'b0; m0_adr = 32'h10; m0_sel = 4'hf;
        @(posedge clk);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k < TO) begin
                checks++;
                if (m0_ack !== 1'b0 || m0_err !== 1'b0 || to_evt !== 1'b0) begin
                    errors++; $display("FAIL lim_wait[%0d]: ack=%b err=%b to_evt=%b exp 0/0/0",
                                       k, m0_ack, m0_err, to_evt);
                end
            end else begin
                checks++;
                if (m0_ack !== 1'b1 || m0_err !== 1'b0 || to_evt !== 1'b0) begin
                    errors++; $display("FAIL lim_ack: ack=%b err=%b to_evt=%b exp 1/0/0",
                                       m0_ack, m0_err, to_evt);
                end
                checks++;
                if (m0_dat_r !== ref_mem[32'h10 >> 2]) begin
                    errors++; $display("FAIL lim_data: %h exp %h", m0_dat_r, ref_mem[32'h10 >> 2]);
                end
            end
        end
        @(posedge clk); #1;
        m0_cs = 1'b0;
        slave_mode = 0;
        model_order(1, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd0, rd1;
        logic a0, e0, a1, e1;
        int n;
        ref_wr(32'h20, 32'h0badf00d, 4'hf);
        mreq(0, 1'b1, 32'h20, 32'h0badf00d, 4'hf, rd0, a0, e0);
        slave_mode = 1;
        m0_cs = 1'b1; m0_we = 1'b1; m0_adr = 32'h20; m0_dat_w = 32'h12345678; m0_sel = 4'hf;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt !== 2'b01 && n < 20);
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL rmid_grant: gnt=%b exp 01", gnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m0_cs = 1'b0;
        slave_mode = 0;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00 || s_cs !== 1'b0 || to_evt !== 1'b0) begin
            errors++; $display("FAIL rmid_ctl: gnt=%b s_cs=%b to_evt=%b exp 00/0/0", gnt, s_cs, to_evt);
        end
        checks++;
        if (s_we !== 1'b0 || s_sel !== 4'h0 || s_adr !== 32'h0 || s_dat_w !== 32'h0) begin
            errors++; $display("FAIL rmid_sbus: we=%b sel=%h adr=%h dat=%h exp 0", s_we, s_sel, s_adr, s_dat_w);
        end
        checks++;
        if (m0_ack !== 1'b0 || m0_err !== 1'b0 || m1_ack !== 1'b0 || m1_err !== 1'b0) begin
            errors++; $display("FAIL rmid_resp: acks/errs not zero");
        end
        @(posedge clk); #1;
        model_last = 1'b1;
        alog.delete();
        fork
            mreq(0, 1'b0, 32'h20, 32'h0, 4'hf, rd0, a0, e0);
            mreq(1, 1'b0, 32'h14, 32'h0, 4'hf, rd1, a1, e1);
        join
        model_order(1, 1);
        checks++;
        if (alog.size() != 2 || alog[0].idx != eord[0]) begin
            errors++; $display("FAIL rmid_tie: first=%0d n=%0d exp m%0d", (alog.size() > 0) ? alog[0].idx : -1,
                               alog.size(), eord[0]);
        end
        checks++;
        if (rd0 !== ref_mem[32'h20 >> 2] || rd1 !== ref_mem[32'h14 >> 2]) begin
            errors++; $display("FAIL rmid_data: %h %h exp %h %h", rd0, rd1,
                               ref_mem[32'h20 >> 2], ref_mem[32'h14 >> 2]);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_cs = 1'b0; m0_we = 1'b0; m0_sel = '0; m0_adr = '0; m0_dat_w = '0;
        m1_cs = 1'b0; m1_we = 1'b0; m1_sel = '0; m1_adr = '0; m1_dat_w = '0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_ack_on_limit();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
